regfile_wb_arbiter: RTL and testbench

- Controller for the single write port of the 16x16 register file. Register file write inputs are WriteReg, DstReg[3:0] and DstData[15:0].
- Two writeback requesters share that port: the ALU result path and the memory-load path.
- Each requester has a valid/ready handshake and a small in-order FIFO. A registered output stage issues at most one register-file write per cycle.
- The block also exports a pending-write mask, used by the hazard/stall logic.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port, through per-source FIFOs and a registered output stage.
// Optional starvation guard: define WB_STARVE_GUARD_EN. Minimum latency is 2 cycles from accept to rf_WriteReg. Ready falls only when a FIFO is full.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_dst,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_dst,
  input  logic [15:0] mem_data,
  output logic        rf_WriteReg,
  output logic [3:0]  rf_DstReg,
  output logic [15:0] rf_DstData,
  output logic [15:0] pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 0) begin : g_param_check
    $error("regfile_wb_arbiter: DEPTH must be a power of two >= 2, STARVE_LIMIT >= 0");
  end

  logic [3:0]    alu_dst_q  [DEPTH];
  logic [15:0]   alu_data_q [DEPTH];
  logic [3:0]    mem_dst_q  [DEPTH];
  logic [15:0]   mem_data_q [DEPTH];
  logic [PW-1:0] alu_rd, alu_wr, mem_rd, mem_wr;
  logic [CW-1:0] alu_cnt, mem_cnt;
  logic          alu_push, mem_push;
  logic          alu_grant, mem_grant;

  // Ready looks only at the registered count, so a full FIFO refuses even when popped.
  assign alu_ready = (alu_cnt != CW'(DEPTH));
  assign mem_ready = (mem_cnt != CW'(DEPTH));
  // Writes to R0 complete the handshake but are never queued.
  assign alu_push  = alu_valid && alu_ready && (alu_dst != 4'd0) && !flush;
  assign mem_push  = mem_valid && mem_ready && (mem_dst != 4'd0) && !flush;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_cnt != '0 && mem_cnt != '0) begin
      if (starve_cnt == SW'(STARVE_LIMIT)) alu_grant = 1'b1;
      else                                 mem_grant = 1'b1;
    end else begin
      alu_grant = (alu_cnt != '0);
      mem_grant = (mem_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush)                     starve_cnt <= '0;
    else if (alu_grant || alu_cnt == '0) starve_cnt <= '0;
    else if (mem_grant)                  starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign mem_grant = (mem_cnt != '0);
  assign alu_grant = (alu_cnt != '0) && (mem_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_dst_q[alu_wr]  <= alu_dst;
      alu_data_q[alu_wr] <= alu_data;
    end
    if (mem_push) begin
      mem_dst_q[mem_wr]  <= mem_dst;
      mem_data_q[mem_wr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rd      <= '0;
      alu_wr      <= '0;
      alu_cnt     <= '0;
      mem_rd      <= '0;
      mem_wr      <= '0;
      mem_cnt     <= '0;
      rf_WriteReg <= 1'b0;
      rf_DstReg   <= '0;
      rf_DstData  <= '0;
    end else if (flush) begin
      alu_rd      <= '0;
      alu_wr      <= '0;
      alu_cnt     <= '0;
      mem_rd      <= '0;
      mem_wr      <= '0;
      mem_cnt     <= '0;
      rf_WriteReg <= 1'b0;
    end else begin
      if (alu_push)  alu_wr <= alu_wr + 1'b1;
      if (alu_grant) alu_rd <= alu_rd + 1'b1;
      if (mem_push)  mem_wr <= mem_wr + 1'b1;
      if (mem_grant) mem_rd <= mem_rd + 1'b1;
      alu_cnt     <= alu_cnt + CW'(alu_push) - CW'(alu_grant);
      mem_cnt     <= mem_cnt + CW'(mem_push) - CW'(mem_grant);
      rf_WriteReg <= alu_grant || mem_grant;
      if (mem_grant) begin
        rf_DstReg  <= mem_dst_q[mem_rd];
        rf_DstData <= mem_data_q[mem_rd];
      end else if (alu_grant) begin
        rf_DstReg  <= alu_dst_q[alu_rd];
        rf_DstData <= alu_data_q[alu_rd];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] a_off;
    logic [PW-1:0] m_off;
    pending_mask = '0;
    a_off        = '0;
    m_off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_off = PW'(i) - alu_rd;
      m_off = PW'(i) - mem_rd;
      if (CW'(a_off) < alu_cnt) pending_mask[alu_dst_q[i]] = 1'b1;
      if (CW'(m_off) < mem_cnt) pending_mask[mem_dst_q[i]] = 1'b1;
    end
    if (rf_WriteReg) pending_mask[rf_DstReg] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus back-pressure, starvation-guard and mid-run reset sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [3:0]  alu_dst, mem_dst, rf_DstReg;
  logic [15:0] alu_data, mem_data, rf_DstData, pending_mask;
  logic        rf_WriteReg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .rf_WriteReg(rf_WriteReg), .rf_DstReg(rf_DstReg), .rf_DstData(rf_DstData),
    .pending_mask(pending_mask)
  );

  typedef struct packed {
    logic        f;
    logic        av;
    logic [3:0]  ad;
    logic [15:0] adat;
    logic        mv;
    logic [3:0]  md;
    logic [15:0] mdat;
    logic        ewe;
    logic [3:0]  edst;
    logic [15:0] edat;
    logic [15:0] emask;
    logic        ear;
    logic        emr;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic av, input logic [3:0] ad, input logic [15:0] adat,
                       input logic mv, input logic [3:0] md, input logic [15:0] mdat);
    flush     = f;
    alu_valid = av;
    alu_dst   = ad;
    alu_data  = adat;
    mem_valid = mv;
    mem_dst   = md;
    mem_data  = mdat;
  endtask

  initial begin
    logic [10:0] bp_we, bp_ar, bp_mr;
    logic [3:0]  bp_dst [11];
    logic [15:0] bp_dat [11];

    // f av ad adat mv md mdat | we dst data mask ar mr
    vt[0]  = '{1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0000, 16'h0008, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd3, 16'h1234, 16'h0008, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd3, 16'h1234, 16'h0000, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b0, 4'd3, 16'h1234, 16'h0000, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd3, 16'h1234, 16'h0060, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd6, 16'hBBBB, 16'h0060, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd5, 16'hAAAA, 16'h0020, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 4'd0, 16'h5555, 1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[12] = '{1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[13] = '{1'b1, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0006, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};
    vt[15] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd5, 16'hAAAA, 16'h0000, 1'b1, 1'b1};

    for (int t = 0; t < 11; t++) begin
      bp_dst[t] = 4'd0;
      bp_dat[t] = 16'h0;
    end
    bp_we = 11'b01111111100;
    bp_dst[2] = 4'd8;  bp_dat[2] = 16'hB000;
    bp_dst[3] = 4'd9;  bp_dat[3] = 16'hB001;
    bp_dst[4] = 4'd10; bp_dat[4] = 16'hB002;
`ifdef WB_STARVE_GUARD_EN
    bp_ar = 11'b11100100011;
    bp_mr = 11'b11111011111;
    bp_dst[5] = 4'd1;  bp_dat[5] = 16'hA000;
    bp_dst[6] = 4'd11; bp_dat[6] = 16'hB003;
    bp_dst[7] = 4'd12; bp_dat[7] = 16'hB004;
    bp_dst[8] = 4'd2;  bp_dat[8] = 16'hA001;
    bp_dst[9] = 4'd6;  bp_dat[9] = 16'hA005;
`else
    bp_ar = 11'b11100000011;
    bp_mr = 11'b11111111111;
    bp_dst[5] = 4'd11; bp_dat[5] = 16'hB003;
    bp_dst[6] = 4'd12; bp_dat[6] = 16'hB004;
    bp_dst[7] = 4'd13; bp_dat[7] = 16'hB005;
    bp_dst[8] = 4'd1;  bp_dat[8] = 16'hA000;
    bp_dst[9] = 4'd2;  bp_dat[9] = 16'hA001;
`endif

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk("reset_we",    0, 16'(rf_WriteReg),  16'h0);
    chk("reset_dst",   0, 16'(rf_DstReg),    16'h0);
    chk("reset_data",  0, rf_DstData,        16'h0);
    chk("reset_mask",  0, pending_mask,      16'h0);
    chk("reset_alu_rdy", 0, 16'(alu_ready),  16'h1);
    chk("reset_mem_rdy", 0, 16'(mem_ready),  16'h1);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("vec_we",      k, 16'(rf_WriteReg), 16'(vt[k].ewe));
      chk("vec_dst",     k, 16'(rf_DstReg),   16'(vt[k].edst));
      chk("vec_data",    k, rf_DstData,       vt[k].edat);
      chk("vec_mask",    k, pending_mask,     vt[k].emask);
      chk("vec_alu_rdy", k, 16'(alu_ready),   16'(vt[k].ear));
      chk("vec_mem_rdy", k, 16'(mem_ready),   16'(vt[k].emr));
      drive(vt[k].f, vt[k].av, vt[k].ad, vt[k].adat, vt[k].mv, vt[k].md, vt[k].mdat);
    end

    // Both sources push every cycle for six cycles, then go idle.
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      chk("bp_alu_rdy", t, 16'(alu_ready),   16'(bp_ar[t]));
      chk("bp_mem_rdy", t, 16'(mem_ready),   16'(bp_mr[t]));
      chk("bp_we",      t, 16'(rf_WriteReg), 16'(bp_we[t]));
      if (bp_we[t]) begin
        chk("bp_dst",  t, 16'(rf_DstReg), 16'(bp_dst[t]));
        chk("bp_data", t, rf_DstData,     bp_dat[t]);
      end
      if (t == 2) chk("bp_mask", t, pending_mask, 16'h0306);
      if (t < 6) drive(1'b0, 1'b1, 4'(1 + t), 16'hA000 + 16'(t), 1'b1, 4'(8 + t), 16'hB000 + 16'(t));
      else       drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    end

    // Reset arrives while a write is still queued.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'h0);
    @(negedge clk);
    chk("rstmid_mask_before", 0, pending_mask, 16'h0080);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_we",   1, 16'(rf_WriteReg), 16'h0);
    chk("rstmid_mask", 1, pending_mask,     16'h0);
    chk("rstmid_dst",  1, 16'(rf_DstReg),   16'h0);
    chk("rstmid_data", 1, rf_DstData,       16'h0);
    @(negedge clk);
    chk("rstmid_we",   2, 16'(rf_WriteReg), 16'h0);
    chk("rstmid_mask", 2, pending_mask,     16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
